// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer.
// Optional feature macro used by this slice: APB_SLVERR_EN.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  // Address bit that selects between PSEL1/PSEL2 slaves upstream; ignored here.
  localparam int SLAVE_SEL_BIT = 8;

  // Number of index bits needed to address reg_count registers (at least 1).
  function automatic int idx_width(input int count);
    if (count > 2) begin
      return $clog2(count);
    end else begin
      return 1;
    end
  endfunction

endpackage : apb_pkg

// File: rtl/apb_slave_if.sv
// APB bus bundle between the master and one completer.
// PSLVERR_o is present only when APB_SLVERR_EN is defined.
interface apb_slave_if #(
  parameter int data_size    = 7,
  parameter int address_size = 8
);

  logic                  PSEL_i;
  logic                  PENABLE_i;
  logic                  PWRITE_i;
  logic [address_size:0] PADDR_i;
  logic [data_size:0]    PWDATA_i;
  logic                  PREADY_o;
  logic [data_size:0]    PRDATA_o;
`ifdef APB_SLVERR_EN
  logic                  PSLVERR_o;
`endif

  modport master (
    output PSEL_i,
    output PENABLE_i,
    output PWRITE_i,
    output PADDR_i,
    output PWDATA_i,
`ifdef APB_SLVERR_EN
    input  PSLVERR_o,
`endif
    input  PREADY_o,
    input  PRDATA_o
  );

  modport slave (
    input  PSEL_i,
    input  PENABLE_i,
    input  PWRITE_i,
    input  PADDR_i,
    input  PWDATA_i,
`ifdef APB_SLVERR_EN
    output PSLVERR_o,
`endif
    output PREADY_o,
    output PRDATA_o
  );

endinterface : apb_slave_if

// File: rtl/apb_slave_regfile.sv
// Register array behind the APB completer: one synchronous write port,
// one combinational read port, cleared by the asynchronous reset.
module apb_slave_regfile #(
  parameter int data_size = 7,
  parameter int reg_count = 16,
  parameter int idx_w     = 4
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               we,
  input  logic [idx_w-1:0]   idx,
  input  logic [data_size:0] wdata,
  output logic [data_size:0] rdata
);

  logic [data_size:0] mem_r [reg_count];

  // Storage: clear on reset, otherwise write the indexed entry when enabled.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < reg_count; i++) begin
        mem_r[i] <= {(data_size + 1){1'b0}};
      end
    end else if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read port: reg_count is a power of two, so every index is in range.
  always_comb begin
    rdata = mem_r[idx];
  end

endmodule : apb_slave_regfile

// File: rtl/apb_slave.sv
// APB completer: decodes PADDR into a small register file and answers single
// reads/writes after wait_cycles wait states.
// Optional feature macro: APB_SLVERR_EN (out-of-range error response).
module apb_slave
  import apb_pkg::*;
#(
  parameter int data_size    = 7,
  parameter int address_size = 8,
  parameter int reg_count    = 16,
  parameter int wait_cycles  = 1
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_slave_if.slave         bus,
  output logic [data_size:0] data_o
);

  localparam int IDX_W = idx_width(reg_count);
  localparam int CNT_W = (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;

  apb_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic               write_r;
  logic [IDX_W-1:0]   idx_s;
  logic               ready_s;
  logic               done_s;
  logic               wr_ok_s;
  logic               rd_ok_s;
  logic               we_s;
  logic [data_size:0] rdata_s;
  logic               unused_paddr_s;

  // Bit 0 and the slave-select bit never take part in decoding.
  assign idx_s          = bus.PADDR_i[IDX_W:1];
  assign unused_paddr_s = ^bus.PADDR_i;

`ifdef APB_SLVERR_EN
  logic                     oor_r;
  logic                     range_s;
  logic [SLAVE_SEL_BIT-1:0] low_addr_s;

  // Any set bit between the index field and the slave-select bit is out of range.
  assign low_addr_s = bus.PADDR_i[SLAVE_SEL_BIT-1:0];
  assign range_s    = |(low_addr_s >> (IDX_W + 1));
  assign wr_ok_s    = write_r & ~oor_r;
  assign rd_ok_s    = ready_s & ~write_r & ~oor_r;
  assign bus.PSLVERR_o = ready_s & oor_r;

  // Out-of-range flag captured with the rest of the setup-phase request.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      oor_r <= 1'b0;
    end else if ((state_r == IDLE) && bus.PSEL_i && !bus.PENABLE_i) begin
      oor_r <= range_s;
    end else begin
      oor_r <= oor_r;
    end
  end
`else
  // Without error responses, upper address bits alias onto the register file.
  assign wr_ok_s = write_r;
  assign rd_ok_s = ready_s & ~write_r;
`endif

  assign ready_s = (state_r == ACCESS) && (cnt_r == {CNT_W{1'b0}});
  assign done_s  = ready_s && bus.PSEL_i && bus.PENABLE_i;
  assign we_s    = done_s && wr_ok_s;

  // Transfer sequencing: latch the request in setup, count wait states in access.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.PSEL_i && !bus.PENABLE_i) begin
            state_r <= SETUP;
            idx_r   <= idx_s;
            write_r <= bus.PWRITE_i;
            cnt_r   <= CNT_W'(wait_cycles);
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          if (bus.PSEL_i) begin
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (!bus.PSEL_i) begin
            state_r <= IDLE;
          end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else if (bus.PENABLE_i) begin
            state_r <= IDLE;
          end else begin
            state_r <= ACCESS;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Mirror of the last value committed to any register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data_o <= {(data_size + 1){1'b0}};
    end else if (we_s) begin
      data_o <= bus.PWDATA_i;
    end else begin
      data_o <= data_o;
    end
  end

  // Read data is only presented while a read is actually completing.
  always_comb begin
    bus.PREADY_o = ready_s;
    if (rd_ok_s) begin
      bus.PRDATA_o = rdata_s;
    end else begin
      bus.PRDATA_o = {(data_size + 1){1'b0}};
    end
  end

  apb_slave_regfile #(
    .data_size (data_size),
    .reg_count (reg_count),
    .idx_w     (IDX_W)
  ) u_regfile (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .we     (we_s),
    .idx    ((we_s) ? idx_r : idx_r),
    .wdata  (bus.PWDATA_i),
    .rdata  (rdata_s)
  );

endmodule : apb_slave

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: three instances (wait_cycles 1, 0, 3)
// share one master; a behavioural register model predicts every response.
module tb_apb_slave;

  logic       PCLK = 1'b0;
  logic       PRESET;
  int         checks = 0;
  int         errors = 0;

  logic       m_psel, m_penable, m_pwrite;
  logic [8:0] m_paddr;
  logic [7:0] m_pwdata;
  int         m_sel;

  logic [7:0] data_a, data_b, data_c;
  logic       obs_ready;
  logic [7:0] obs_rdata, obs_data;

  // Behavioural model: per-instance register contents and last written value.
  logic [7:0] mem  [3][16];
  logic [7:0] last [3];
  int         waits [3] = '{1, 0, 3};

`ifdef APB_SLVERR_EN
  localparam bit SLVERR = 1'b1;
  logic obs_err;
`else
  localparam bit SLVERR = 1'b0;
`endif

  always #5 PCLK = ~PCLK;

  apb_slave_if bus_a ();
  apb_slave_if bus_b ();
  apb_slave_if bus_c ();

  assign bus_a.PSEL_i = m_psel && (m_sel == 0);
  assign bus_b.PSEL_i = m_psel && (m_sel == 1);
  assign bus_c.PSEL_i = m_psel && (m_sel == 2);
  assign bus_a.PENABLE_i = m_penable;
  assign bus_b.PENABLE_i = m_penable;
  assign bus_c.PENABLE_i = m_penable;
  assign bus_a.PWRITE_i = m_pwrite;
  assign bus_b.PWRITE_i = m_pwrite;
  assign bus_c.PWRITE_i = m_pwrite;
  assign bus_a.PADDR_i = m_paddr;
  assign bus_b.PADDR_i = m_paddr;
  assign bus_c.PADDR_i = m_paddr;
  assign bus_a.PWDATA_i = m_pwdata;
  assign bus_b.PWDATA_i = m_pwdata;
  assign bus_c.PWDATA_i = m_pwdata;

  apb_slave #(.wait_cycles(1)) dut_a (.PCLK(PCLK), .PRESET(PRESET), .bus(bus_a), .data_o(data_a));
  apb_slave #(.wait_cycles(0)) dut_b (.PCLK(PCLK), .PRESET(PRESET), .bus(bus_b), .data_o(data_b));
  apb_slave #(.wait_cycles(3)) dut_c (.PCLK(PCLK), .PRESET(PRESET), .bus(bus_c), .data_o(data_c));

  always_comb begin
    case (m_sel)
      0: begin
        obs_ready = bus_a.PREADY_o; obs_rdata = bus_a.PRDATA_o; obs_data = data_a;
      end
      1: begin
        obs_ready = bus_b.PREADY_o; obs_rdata = bus_b.PRDATA_o; obs_data = data_b;
      end
      default: begin
        obs_ready = bus_c.PREADY_o; obs_rdata = bus_c.PRDATA_o; obs_data = data_c;
      end
    endcase
`ifdef APB_SLVERR_EN
    case (m_sel)
      0:       obs_err = bus_a.PSLVERR_o;
      1:       obs_err = bus_b.PSLVERR_o;
      default: obs_err = bus_c.PSLVERR_o;
    endcase
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer to instance s, checked against the model.
  task automatic xfer(input int s, input logic wr, input logic [8:0] addr, input logic [7:0] wdata);
    int         low;
    logic [3:0] idx;
    logic       oor;
    logic [7:0] exp_rd;
    idx = addr[4:1];
    oor = SLVERR && (addr[7:5] != 3'b000);
    @(negedge PCLK);
    m_sel = s; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr;
    m_pwdata = 8'($urandom);
    @(negedge PCLK);
    chk("setup_ready", obs_ready, 1'b0);
    m_penable = 1'b1; m_pwdata = wdata;
    @(negedge PCLK);
    low = 0;
    while (obs_ready !== 1'b1 && low < 20) begin
      chk("wait_rdata", obs_rdata, 8'h00);
      low++;
      @(negedge PCLK);
    end
    chk("wait_states", low, waits[s]);
    exp_rd = (wr || oor) ? 8'h00 : mem[s][idx];
    chk("prdata", obs_rdata, exp_rd);
`ifdef APB_SLVERR_EN
    chk("pslverr", obs_err, oor);
`endif
    @(negedge PCLK);
    if (wr && !oor) begin
      mem[s][idx] = wdata;
      last[s] = wdata;
    end
    m_psel = 1'b0; m_penable = 1'b0;
    chk("idle_ready", obs_ready, 1'b0);
    chk("data_o", obs_data, last[s]);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      last[s] = 8'h00;
      for (int i = 0; i < 16; i++) mem[s][i] = 8'h00;
    end
    m_sel = 0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    m_paddr = 9'h000; m_pwdata = 8'h00;
    PRESET = 1'b1;

    // Reset state of every instance.
    #2;
    for (int s = 0; s < 3; s++) begin
      m_sel = s;
      #1;
      chk("rst_ready", obs_ready, 1'b0);
      chk("rst_rdata", obs_rdata, 8'h00);
      chk("rst_data_o", obs_data, 8'h00);
    end
    @(negedge PCLK);
    PRESET = 1'b0;

    // Write then read, one wait state; bit-8 aliasing and idx 10.
    xfer(0, 1'b1, 9'h002, 8'h5A);
    xfer(0, 1'b0, 9'h002, 8'h00);
    xfer(0, 1'b0, 9'h102, 8'h00);
    xfer(0, 1'b1, 9'h014, 8'h0A);
    xfer(0, 1'b0, 9'h014, 8'h00);

    // Zero-wait and three-wait instances.
    xfer(1, 1'b1, 9'h006, 8'hC3);
    xfer(1, 1'b0, 9'h006, 8'h00);
    xfer(2, 1'b1, 9'h01E, 8'h81);
    xfer(2, 1'b0, 9'h01E, 8'h00);

    // Abort a write of 0xFF to idx 2 during its wait state.
    xfer(0, 1'b1, 9'h004, 8'h33);
    @(negedge PCLK);
    m_sel = 0; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 9'h004;
    @(negedge PCLK);
    m_penable = 1'b1; m_pwdata = 8'hFF;
    @(negedge PCLK);
    chk("abort_wait_ready", obs_ready, 1'b0);
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge PCLK);
    chk("abort_ready", obs_ready, 1'b0);
    chk("abort_data_o", obs_data, last[0]);
    @(negedge PCLK);
    chk("abort_idle_ready", obs_ready, 1'b0);
    xfer(0, 1'b0, 9'h004, 8'h00);

    // Range bits set: error response with the macro, alias onto reg[0] without.
    xfer(0, 1'b1, 9'h040, 8'h77);
    xfer(0, 1'b0, 9'h000, 8'h00);
    xfer(0, 1'b0, 9'h040, 8'h00);

    // Randomized traffic across all three instances.
    for (int n = 0; n < 40; n++) begin
      xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom));
    end

    // Reset asserted while a read is completing in ACCESS.
    xfer(0, 1'b1, 9'h008, 8'hA5);
    @(negedge PCLK);
    m_sel = 0; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 9'h008;
    @(negedge PCLK);
    m_penable = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_ready", obs_ready, 1'b1);
    chk("pre_rst_rdata", obs_rdata, 8'hA5);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_ready", obs_ready, 1'b0);
    chk("mid_rst_rdata", obs_rdata, 8'h00);
    chk("mid_rst_data_o", obs_data, 8'h00);
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int s = 0; s < 3; s++) begin
      last[s] = 8'h00;
      for (int i = 0; i < 16; i++) mem[s][i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 9'(i * 2), 8'h00);
    end
    xfer(2, 1'b0, 9'h01E, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_apb_slave
